booth_multiplier: RTL
=====================

# booth_multiplier

Sequential signed 32×32 multiplier using radix-4 Booth recoding, producing a 64-bit product split into `Hi`/`Lo` words. It is the multiply counterpart to the datapath's divider. It sits beside the ALU and is started by the control unit for MUL. Because it is multi-cycle, it exposes a start/busy/done handshake so control can stall until the product is ready.

## Interface
- `WIDTH`, default 32: operand width; must be even and ≥4. Product is 2·WIDTH.
- `clock` in 1: single clock; all state updates on rising edge.
- `clear_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `M` in WIDTH: multiplicand, two's complement.
- `Q` in WIDTH: multiplier, two's complement.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse; `Hi`/`Lo` valid from this cycle on.
- `Hi` out WIDTH: product[2·WIDTH-1:WIDTH].
- `Lo` out WIDTH: product[WIDTH-1:0].

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE after the WIDTH/2-th step.
  - DONE→IDLE unconditionally.
- On accept:
  - Latch `M` into `m_reg` (WIDTH+2 bits, sign-extended).
  - Load the working register P = {A, Qr, q₋₁}, where A is WIDTH+2 bits and cleared, Qr = `Q`, and q₋₁ = 0.
  - Clear the step counter, which is ceil(log2(WIDTH/2))+1 bits.
- Each RUN cycle:
  - Recode {Qr[1], Qr[0], q₋₁}:
    - 000 or 111: add 0.
    - 001 or 010: add +m_reg.
    - 011: add +2·m_reg.
    - 100: add −2·m_reg.
    - 101 or 110: add −m_reg.
  - Add the selected value to A, modulo 2^(WIDTH+2).
  - Arithmetic-shift the whole of P right by 2, replicating the sign bit of A.
  - Increment the counter.
- The WIDTH+2 accumulator width is mandatory so ±2·m_reg (including 2·(−2^(WIDTH−1))) never overflows.
- After step WIDTH/2:
  - Product = {A[WIDTH−1:0], Qr}, the low 2·WIDTH bits.
  - Register the product into `Hi`/`Lo` on the same edge as the RUN→DONE transition.
- `Hi`/`Lo` hold their value until the next completion. They do not change during RUN.
- `start` while `busy` is ignored: not queued, and operands are not re-latched. Operands may change freely after accept.
- `start` in the DONE cycle is ignored. The next operation can be accepted in IDLE, one cycle later.
- Reset values: state IDLE, `busy` 0, `done` 0, `Hi` 0, `Lo` 0, P 0, counter 0.
- `clear_n` low mid-operation aborts immediately to reset values. No partial result is ever exposed.

## Timing
- Accept at edge k (IDLE, `start`=1). Steps occur at edges k+1 … k+WIDTH/2.
- For WIDTH=32:
  - 16 steps.
  - Product registered, state DONE, `done`=1 after edge k+16.
  - Back to IDLE after edge k+17.
- Latency from the accept edge to `done` high is WIDTH/2 cycles. Throughput is one product per WIDTH/2+2 cycles with back-to-back `start`.
- `busy` rises after edge k and falls after edge k+17.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `mul_pkg`:
  - State encoding `mul_state_t` (IDLE, RUN, DONE).
  - Booth select encoding `booth_sel_t` (ZERO, POS1, POS2, NEG1, NEG2).
  - Constant `MUL_STEPS = WIDTH/2`.
- One sub-module `booth_recoder`: combinational, 3-bit input to `booth_sel_t` output. Instantiated once.
- Adder, shifter and FSM are in the top level.

## Test plan
- Reset with `clear_n`=0 → all outputs 0, `busy`=0. Then M=6, Q=7, `start` → after 16 cycles `done` pulses, Hi=0x00000000, Lo=0x0000002A.
- M=−3 (0xFFFFFFFD), Q=5 → Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
- M=Q=0x80000000 → Hi=0x40000000, Lo=0x00000000 (exercises the −2·m_reg width). M=Q=0x7FFFFFFF → Hi=0x3FFFFFFF, Lo=0x00000001.
- M=Q=0xFFFFFFFF (−1·−1) → Hi=0, Lo=1.
  - Then assert `start` with M=2, Q=2 during RUN → ignored.
  - Result stays 1; `done` pulses exactly once.
- Start M=9, Q=9; pulse `clear_n` low at step 8 → outputs 0 immediately, no `done`. Then M=9, Q=9 → Lo=0x51.
- Random signed operands (≥1000), back-to-back `start` in IDLE → Hi:Lo equals the reference 64-bit signed product. `done` is spaced exactly 18 cycles apart.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_sel_t;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_STEPS = MUL_WIDTH / 2;

  // Number of radix-4 steps for an arbitrary (even) operand width.
  function automatic int mul_steps(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth digit recoder: {q[i+1], q[i], q[i-1]} to a partial-product select.
module booth_recoder
  import mul_pkg::*;
(
  input  logic [2:0] bits,
  output booth_sel_t sel
);

  always_comb begin
    // NOTE: defaulting the output before the case guarantees no latch is inferred.
    sel = ZERO;
    case (bits)
      3'b000, 3'b111: sel = ZERO;
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed WIDTHxWIDTH multiplier, radix-4 Booth, WIDTH/2 steps per product.
// start/busy/done handshake; Hi/Lo hold the last completed product.
module booth_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int STEPS = mul_steps(WIDTH);
  localparam int CW    = $clog2(STEPS) + 1;
  // Two guard bits so that +/-2*M for the most negative M still fits.
  localparam int AW    = WIDTH + 2;

  mul_state_t       state, state_nxt;
  logic             load, step, last;
  logic [AW-1:0]    m_reg;
  logic [AW-1:0]    a_reg;
  logic [WIDTH-1:0] qr_reg;
  logic             q_m1;
  logic [CW-1:0]    cnt;

  booth_sel_t       sel;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    a_sum;
  logic [AW-1:0]    a_nxt;
  logic [WIDTH-1:0] qr_nxt;
  logic             q_m1_nxt;

  assign last = (cnt == CW'(STEPS - 1));

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  booth_recoder u_recoder (
    .bits ({qr_reg[1:0], q_m1}),
    .sel  (sel)
  );

  always_comb begin
    addend = '0;
    case (sel)
      POS1:    addend = m_reg;
      POS2:    addend = m_reg << 1;
      NEG1:    addend = -m_reg;
      NEG2:    addend = -(m_reg << 1);
      default: addend = '0;
    endcase
  end

  // Accumulate, then arithmetic-shift {A, Qr, q-1} right by two.
  assign a_sum    = a_reg + addend;
  assign a_nxt    = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
  assign qr_nxt   = {a_sum[1:0], qr_reg[WIDTH-1:2]};
  assign q_m1_nxt = qr_reg[1];

  // NOTE: every datapath flop, including the working register, is reset so an
  // abort leaves no stale partial product behind.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      m_reg  <= '0;
      a_reg  <= '0;
      qr_reg <= '0;
      q_m1   <= 1'b0;
      cnt    <= '0;
      Hi     <= '0;
      Lo     <= '0;
    end else if (load) begin
      // NOTE: sequential state uses non-blocking assignments only.
      m_reg  <= {{2{M[WIDTH-1]}}, M};
      a_reg  <= '0;
      qr_reg <= Q;
      q_m1   <= 1'b0;
      cnt    <= '0;
    end else if (step) begin
      a_reg  <= a_nxt;
      qr_reg <= qr_nxt;
      q_m1   <= q_m1_nxt;
      cnt    <= cnt + CW'(1);
      if (last) begin
        Hi <= a_nxt[WIDTH-1:0];
        Lo <= qr_nxt;
      end
    end
  end

endmodule
